// File: rtl/load_store_unit.sv
// RV32 memory stage: accepts one load/store from execute, runs a single
// word-aligned access on a valid/ready memory port, and returns aligned,
// extended load data to writeback. It flags illegal funct3, misaligned
// addresses and memory timeouts with a one-cycle fault pulse.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  state_t      state_q;
  logic        req_ready_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  logic        mem_valid_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_wstrb_q;
  logic [31:0] mem_wdata_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        done_q;
  logic        fault_q;
  logic [1:0]  fault_cause_q;

  // Loads allow 000/001/010/100/101; stores allow 000/001/010.
  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 >= 3'b011);
    else
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // f3[1:0] encodes the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b01:   return o[0];
      2'b10:   return (o != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00:   return 4'b0001 << o;
      2'b01:   return 4'b0011 << o;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across lanes so the strobes pick the lane.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Select the addressed byte/half of the read word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] o,
                                              input logic [31:0] rdata);
    logic [31:0]        sh;
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [31:0] ext;
    sh  = rdata >> {o, 3'b000};
    b   = sh[7:0];
    h   = o[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  ext = {{24{b[7]}}, b};
      3'b001:  ext = {{16{h[15]}}, h};
      3'b100:  ext = {24'd0, b};
      3'b101:  ext = {16'd0, h};
      default: ext = rdata;
    endcase
    return ext;
  endfunction

  assign cnt_d = cnt_q + 32'd1;

  // Request/response sequencing with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      rd_q          <= 5'd0;
      cnt_q         <= 32'd0;
      mem_valid_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wstrb_q   <= 4'b0000;
      mem_wdata_q   <= 32'd0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'd0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= 2'b00;
    end else begin
      wb_valid_q <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            f3_q        <= req_funct3;
            off_q       <= req_addr[1:0];
            rd_q        <= req_rd;
            cnt_q       <= 32'd0;
            if (is_illegal(req_we, req_funct3)) begin
              state_q       <= S_FAULT;
              fault_q       <= 1'b1;
              fault_cause_q <= CAUSE_ILLEGAL;
            end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
              state_q       <= S_FAULT;
              fault_q       <= 1'b1;
              fault_cause_q <= CAUSE_MISALIGN;
            end else begin
              state_q     <= S_REQ;
              mem_valid_q <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wstrb_q <= req_we ? store_strobe(req_funct3, req_addr[1:0]) : 4'b0000;
              mem_wdata_q <= req_we ? store_data(req_funct3, req_wdata) : 32'd0;
            end
          end
        end
        S_REQ: begin
          // A completing handshake takes precedence over the timeout.
          if (mem_ready) begin
            state_q     <= S_DONE;
            mem_valid_q <= 1'b0;
            done_q      <= 1'b1;
            if (!we_q) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= rd_q;
              wb_data_q  <= load_extend(f3_q, off_q, mem_rdata);
            end
          end else begin
            cnt_q <= cnt_d;
            if ((TO_LIM != 32'd0) && (cnt_d == TO_LIM)) begin
              state_q       <= S_FAULT;
              mem_valid_q   <= 1'b0;
              fault_q       <= 1'b1;
              fault_cause_q <= CAUSE_TIMEOUT;
            end
          end
        end
        S_DONE, S_FAULT: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign mem_valid   = mem_valid_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of load/store vectors with
// hand-computed results, plus sequences for timeout, idle mem_ready and
// reset during an access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        fault;
  logic [1:0]  fault_cause;

  int tests = 0;
  int fails = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .done(done), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          waits;
    logic        e_fault;
    logic [1:0]  e_cause;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                     input logic [31:0] rdata, input int waits, input logic ef,
                     input logic [1:0] ec, input logic [31:0] ea, input logic [3:0] es,
                     input logic [31:0] ew, input logic [31:0] ewb);
    vec_t v;
    v.name = n; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.rd = rd;
    v.rdata = rdata; v.waits = waits; v.e_fault = ef; v.e_cause = ec;
    v.e_addr = ea; v.e_strb = es; v.e_wdata = ew; v.e_wb = ewb;
    vecs.push_back(v);
  endtask

  // Present a request for one edge; returns just after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_rd     = rd;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    chk({v.name, ".req_ready"}, 32'(req_ready), 32'd1);
    issue(v.we, v.f3, v.addr, v.wdata, v.rd);
    if (v.e_fault) begin
      chk({v.name, ".fault"}, 32'(fault), 32'd1);
      chk({v.name, ".cause"}, 32'(fault_cause), 32'(v.e_cause));
      chk({v.name, ".mem_valid"}, 32'(mem_valid), 32'd0);
      chk({v.name, ".done"}, 32'(done), 32'd0);
      chk({v.name, ".wb_valid"}, 32'(wb_valid), 32'd0);
      step();
      chk({v.name, ".ready_after"}, 32'(req_ready), 32'd1);
      chk({v.name, ".fault_after"}, 32'(fault), 32'd0);
    end else begin
      chk({v.name, ".mem_valid"}, 32'(mem_valid), 32'd1);
      chk({v.name, ".mem_addr"}, mem_addr, v.e_addr);
      chk({v.name, ".mem_we"}, 32'(mem_we), 32'(v.we));
      chk({v.name, ".wstrb"}, 32'(mem_wstrb), 32'(v.e_strb));
      if (v.we) chk({v.name, ".wdata"}, mem_wdata, v.e_wdata);
      for (int i = 0; i < v.waits; i++) begin
        mem_ready = 1'b0;
        step();
        chk({v.name, ".wait_valid"}, 32'(mem_valid), 32'd1);
        chk({v.name, ".wait_fault"}, 32'(fault), 32'd0);
        chk({v.name, ".wait_addr"}, mem_addr, v.e_addr);
      end
      mem_ready = 1'b1;
      mem_rdata = v.rdata;
      step();
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      chk({v.name, ".done"}, 32'(done), 32'd1);
      chk({v.name, ".fault"}, 32'(fault), 32'd0);
      chk({v.name, ".mem_valid_off"}, 32'(mem_valid), 32'd0);
      chk({v.name, ".wb_valid"}, 32'(wb_valid), 32'(!v.we));
      if (!v.we) begin
        chk({v.name, ".wb_data"}, wb_data, v.e_wb);
        chk({v.name, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
      end
      chk({v.name, ".ready_in_done"}, 32'(req_ready), 32'd0);
      step();
      chk({v.name, ".ready_after"}, 32'(req_ready), 32'd1);
      chk({v.name, ".done_after"}, 32'(done), 32'd0);
      chk({v.name, ".wb_after"}, 32'(wb_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_ready = 1'b0; mem_rdata = 32'h0;

    //   name     we f3      addr          wdata         rd  rdata        w  flt cause addr          strb     wdata         wb
    add("LW",     0, 3'b010, 32'h100, 32'h0,         5,  32'hDEADBEEF, 2, 0, 2'b00, 32'h100, 4'b0000, 32'h0,        32'hDEADBEEF);
    add("LB",     0, 3'b000, 32'h103, 32'h0,         6,  32'h80112233, 0, 0, 2'b00, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80);
    add("LBU",    0, 3'b100, 32'h103, 32'h0,         7,  32'h80112233, 1, 0, 2'b00, 32'h100, 4'b0000, 32'h0,        32'h00000080);
    add("LH",     0, 3'b001, 32'h102, 32'h0,         8,  32'h80112233, 0, 0, 2'b00, 32'h100, 4'b0000, 32'h0,        32'hFFFF8011);
    add("LHU",    0, 3'b101, 32'h100, 32'h0,         9,  32'h80112233, 0, 0, 2'b00, 32'h100, 4'b0000, 32'h0,        32'h00002233);
    add("LB1",    0, 3'b000, 32'h101, 32'h0,         10, 32'h80112233, 0, 0, 2'b00, 32'h100, 4'b0000, 32'h0,        32'h00000022);
    add("SB",     1, 3'b000, 32'h201, 32'h000000A5, 0,  32'h0,        0, 0, 2'b00, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0);
    add("SH",     1, 3'b001, 32'h202, 32'h00001234, 0,  32'h0,        1, 0, 2'b00, 32'h200, 4'b1100, 32'h12341234, 32'h0);
    add("SW",     1, 3'b010, 32'h300, 32'hCAFEF00D, 0,  32'h0,        2, 0, 2'b00, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h0);
    add("SWmis",  1, 3'b010, 32'h302, 32'h1,         0,  32'h0,        0, 1, 2'b01, 32'h0,   4'b0000, 32'h0,        32'h0);
    add("LHmis",  0, 3'b001, 32'h101, 32'h0,         3,  32'h0,        0, 1, 2'b01, 32'h0,   4'b0000, 32'h0,        32'h0);
    add("Lf011",  0, 3'b011, 32'h100, 32'h0,         3,  32'h0,        0, 1, 2'b10, 32'h0,   4'b0000, 32'h0,        32'h0);
    add("Lf110",  0, 3'b110, 32'h103, 32'h0,         3,  32'h0,        0, 1, 2'b10, 32'h0,   4'b0000, 32'h0,        32'h0);
    add("Sf011",  1, 3'b011, 32'h100, 32'h0,         0,  32'h0,        0, 1, 2'b10, 32'h0,   4'b0000, 32'h0,        32'h0);
    add("LWw3",   0, 3'b010, 32'h404, 32'h0,         11, 32'h12345678, 3, 0, 2'b00, 32'h404, 4'b0000, 32'h0,        32'h12345678);
    add("LWx0",   0, 3'b010, 32'h008, 32'h0,         0,  32'h000000FF, 0, 0, 2'b00, 32'h008, 4'b0000, 32'h0,        32'h000000FF);

    step(); step();
    rst = 1'b0;
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.mem_valid", 32'(mem_valid), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst.wb_data", wb_data, 32'h0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // mem_ready while idle must not produce any activity.
    mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    chk("idle_rdy.mem_valid", 32'(mem_valid), 32'd0);
    chk("idle_rdy.done", 32'(done), 32'd0);
    chk("idle_rdy.wb_valid", 32'(wb_valid), 32'd0);

    // Timeout: mem_ready never arrives, mem_valid holds for four cycles.
    issue(1'b0, 3'b010, 32'h500, 32'h0, 5'd4);
    for (int i = 0; i < 4; i++) begin
      chk("tmo.mem_valid", 32'(mem_valid), 32'd1);
      chk("tmo.no_fault", 32'(fault), 32'd0);
      step();
    end
    chk("tmo.fault", 32'(fault), 32'd1);
    chk("tmo.cause", 32'(fault_cause), 32'd3);
    chk("tmo.mem_valid_off", 32'(mem_valid), 32'd0);
    chk("tmo.done", 32'(done), 32'd0);
    chk("tmo.wb_valid", 32'(wb_valid), 32'd0);
    step();
    chk("tmo.ready_after", 32'(req_ready), 32'd1);

    // Reset in the middle of an access abandons it silently.
    issue(1'b0, 3'b010, 32'h600, 32'h0, 5'd12);
    chk("mrst.mem_valid", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h55555555;
    step();
    rst = 1'b0;
    mem_ready = 1'b0;
    chk("mrst.mem_valid_off", 32'(mem_valid), 32'd0);
    chk("mrst.req_ready", 32'(req_ready), 32'd1);
    chk("mrst.mem_addr", mem_addr, 32'h0);
    chk("mrst.done", 32'(done), 32'd0);
    chk("mrst.wb_valid", 32'(wb_valid), 32'd0);
    chk("mrst.fault", 32'(fault), 32'd0);
    step();
    chk("mrst.done2", 32'(done), 32'd0);
    chk("mrst.wb_valid2", 32'(wb_valid), 32'd0);
    chk("mrst.fault2", 32'(fault), 32'd0);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
